// File: rtl/read_iq_ctrl_pkg.sv
// read_iq_ctrl_pkg: shared types and defaults for the read_iq run controller.
package read_iq_ctrl_pkg;

    localparam int IQ_CTRL_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } iq_ctrl_state_t;

endpackage

// File: rtl/iq_run_counter.sv
// iq_run_counter: CNT_WIDTH up-counter with synchronous clear, increment,
// terminal compare against the run length and a "reaches length this cycle" flag.
module iq_run_counter
    import read_iq_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = IQ_CTRL_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_inc,
    input  logic [CNT_WIDTH-1:0] i_len,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_term,
    output logic                 o_hit
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_inc;

    assign w_count_inc = r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign o_count     = r_count;
    assign o_term      = (r_count == i_len);
    // Asserted in the cycle whose increment makes the count equal the length.
    assign o_hit       = i_inc && (w_count_inc == i_len);

    // Count register: clear has priority over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/read_iq_ctrl.sv
// read_iq_ctrl: admits exactly N IQ words into read_iq, counts the I/Q pairs
// written out and reports done. Optional lockstep checker is enabled by
// defining READ_IQ_CTRL_LOCKSTEP_CHK_EN.
module read_iq_ctrl
    import read_iq_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = IQ_CTRL_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [CNT_WIDTH-1:0] i_run_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_pairs_done,
    input  logic                 i_src_empty,
    output logic                 o_src_rd_en,
    output logic                 o_dp_empty,
    input  logic                 i_dp_rd_en,
    input  logic                 i_i_full,
    input  logic                 i_q_full,
    output logic                 o_dp_full,
    input  logic                 i_dp_i_wr_en,
    input  logic                 i_dp_q_wr_en,
    output logic                 o_lockstep_err
);

    iq_ctrl_state_t r_state;
    iq_ctrl_state_t w_next;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] w_words_cnt;
    logic r_busy;
    logic r_done;
    logic w_start_acc;
    logic w_allow;
    logic w_busy_st;
    logic w_words_term, w_words_hit;
    logic w_pairs_term, w_pairs_hit;
    logic w_pair_wr;
    logic w_pair_inc;

    // Abort wins over start; start is only honoured when not busy.
    assign w_start_acc = i_start && !i_abort &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_busy_st   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_allow     = (r_state == ST_RUN) && !w_words_term;

    assign o_dp_empty  = i_src_empty | !w_allow;
    assign o_src_rd_en = i_dp_rd_en & w_allow & !i_src_empty & !i_abort;
    // A shared full flag stalls I and Q together so their writes never split.
    assign o_dp_full   = i_i_full | i_q_full;

`ifdef READ_IQ_CTRL_LOCKSTEP_CHK_EN
    logic r_lockstep_err;
    assign w_pair_wr = i_dp_i_wr_en & i_dp_q_wr_en;

    // Sticky lockstep flag: split writes or reads outside the admitted window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lockstep_err <= 1'b0;
        end else if (w_start_acc) begin
            r_lockstep_err <= 1'b0;
        end else if ((i_dp_i_wr_en != i_dp_q_wr_en) || (i_dp_rd_en && !w_allow)) begin
            r_lockstep_err <= 1'b1;
        end else begin
            r_lockstep_err <= r_lockstep_err;
        end
    end
    assign o_lockstep_err = r_lockstep_err;
`else
    assign w_pair_wr      = i_dp_i_wr_en;
    assign o_lockstep_err = 1'b0;
`endif

    // Pairs only count while a run is live; an abort freezes the count.
    assign w_pair_inc = w_pair_wr & w_busy_st & !i_abort & !w_pairs_term;

    iq_run_counter #(.CNT_WIDTH(CNT_WIDTH)) u_words (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_start_acc),
        .i_inc   (o_src_rd_en),
        .i_len   (r_len),
        .o_count (w_words_cnt),
        .o_term  (w_words_term),
        .o_hit   (w_words_hit)
    );

    iq_run_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pairs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_start_acc),
        .i_inc   (w_pair_inc),
        .i_len   (r_len),
        .o_count (o_pairs_done),
        .o_term  (w_pairs_term),
        .o_hit   (w_pairs_hit)
    );

    // Next-state logic for the run FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) begin
                    if (i_run_len == {CNT_WIDTH{1'b0}}) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_RUN;
                    end
                end else begin
                    w_next = r_state;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (w_words_hit || w_words_term) begin
                    if (w_pairs_hit || w_pairs_term) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_DRAIN;
                    end
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (w_pairs_hit || w_pairs_term) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_DRAIN;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_RUN) || (w_next == ST_DRAIN);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Run length is captured only when a start is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= {CNT_WIDTH{1'b0}};
        end else if (w_start_acc) begin
            r_len <= i_run_len;
        end else begin
            r_len <= r_len;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_read_iq_ctrl.sv
// Directed self-checking bench for read_iq_ctrl with a simple read_iq and FIFO model.
module tb_read_iq_ctrl;
    import read_iq_ctrl_pkg::*;
    localparam int W = IQ_CTRL_CNT_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [W-1:0] run_len = '0;
    logic i_full = 1'b0;
    logic q_full = 1'b0;
    logic force_i = 1'b0;
    logic busy, done, src_rd_en, dp_empty, dp_full, lockstep_err;
    logic [W-1:0] pairs_done;

    int src_added = 0;
    int src_taken = 0;
    int rd_cnt = 0;
    int i_cnt = 0;
    int q_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic m_pend;

    wire src_empty = (src_added == src_taken);
    wire dp_rd_en  = !dp_empty && !dp_full && !m_pend;
    wire model_wr  = m_pend && !dp_full;
    wire dp_i_wr   = model_wr | force_i;
    wire dp_q_wr   = model_wr;

    always #5 clk = ~clk;

    read_iq_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_run_len(run_len), .o_busy(busy), .o_done(done), .o_pairs_done(pairs_done),
        .i_src_empty(src_empty), .o_src_rd_en(src_rd_en), .o_dp_empty(dp_empty),
        .i_dp_rd_en(dp_rd_en), .i_i_full(i_full), .i_q_full(q_full), .o_dp_full(dp_full),
        .i_dp_i_wr_en(dp_i_wr), .i_dp_q_wr_en(dp_q_wr), .o_lockstep_err(lockstep_err)
    );

    // read_iq model: one word in flight, pair written when outputs not full.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_pend <= 1'b0;
        else if (src_rd_en) m_pend <= 1'b1;
        else if (model_wr) m_pend <= 1'b0;
    end

    // Source FIFO pops and output FIFO pushes.
    always @(posedge clk) begin
        if (src_rd_en) begin
            src_taken <= src_taken + 1;
            rd_cnt    <= rd_cnt + 1;
        end
        if (dp_i_wr) i_cnt <= i_cnt + 1;
        if (dp_q_wr) q_cnt <= q_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int len);
        run_len = W'(len);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, i0, q0, p0, bad, n;
        logic exp_err;
`ifdef READ_IQ_CTRL_LOCKSTEP_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // Reset values
        i_full = 1'b1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_src_rd_en", 32'(src_rd_en), 32'd0);
        check("rst_dp_empty", 32'(dp_empty), 32'd1);
        check("rst_pairs", 32'(pairs_done), 32'd0);
        check("rst_lockstep", 32'(lockstep_err), 32'd0);
        check("rst_dp_full_hi", 32'(dp_full), 32'd1);
        i_full = 1'b0;
        #1;
        check("rst_dp_full_lo", 32'(dp_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic run: 8 of 20 words
        src_added = src_added + 20;
        r0 = rd_cnt;
        pulse_start(8);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_first_rd", 32'(src_rd_en), 32'd1);
        wait_done("basic_done", 100);
        check("basic_reads", 32'(rd_cnt - r0), 32'd8);
        check("basic_pairs", 32'(pairs_done), 32'd8);
        check("basic_left", 32'(src_added - src_taken), 32'd12);
        check("basic_busy_lo", 32'(busy), 32'd0);

        // Zero length
        r0 = rd_cnt;
        pulse_start(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_pairs", 32'(pairs_done), 32'd0);
        step();
        check("zero_reads", 32'(rd_cnt - r0), 32'd0);
        check("zero_busy2", 32'(busy), 32'd0);

        // Backpressure on Q for cycles 5..30
        src_added = src_added + 16;
        i0 = i_cnt;
        q0 = q_cnt;
        pulse_start(16);
        repeat (4) step();
        q_full = 1'b1;
        #1;
        p0 = int'(pairs_done);
        r0 = i_cnt;
        bad = 0;
        repeat (26) begin
            if (!dp_full) bad++;
            step();
        end
        check("bp_dp_full", 32'(bad), 32'd0);
        check("bp_pairs_hold", 32'(pairs_done), 32'(p0));
        check("bp_no_wr", 32'(i_cnt - r0), 32'd0);
        check("bp_still_busy", 32'(busy), 32'd1);
        q_full = 1'b0;
        wait_done("bp_done", 200);
        check("bp_i_cnt", 32'(i_cnt - i0), 32'd16);
        check("bp_q_cnt", 32'(q_cnt - q0), 32'd16);
        check("bp_pairs", 32'(pairs_done), 32'd16);

        // Abort after 10 pairs, then a short run
        src_added = src_added + 200;
        pulse_start(100);
        n = 0;
        while (pairs_done != W'(10) && n < 300) begin
            step();
            n++;
        end
        check("abort_reach10", 32'(pairs_done), 32'd10);
        abort = 1'b1;
        #1;
        check("abort_rd_off", 32'(src_rd_en), 32'd0);
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pairs", 32'(pairs_done), 32'd10);
        step();
        check("abort_pairs_hold", 32'(pairs_done), 32'd10);
        pulse_start(4);
        wait_done("restart_done", 100);
        check("restart_pairs", 32'(pairs_done), 32'd4);

        // Starved source
        src_added = src_taken;
        pulse_start(5);
        bad = 0;
        repeat (50) begin
            if (!dp_empty || !busy || done || src_rd_en) bad++;
            step();
        end
        check("starve_hold", 32'(bad), 32'd0);
        check("starve_pairs", 32'(pairs_done), 32'd0);
        src_added = src_added + 5;
        wait_done("starve_done", 100);
        check("starve_pairs5", 32'(pairs_done), 32'd5);
        check("starve_src_empty", 32'(src_empty), 32'd1);

        // Asynchronous reset mid-run
        src_added = src_added + 20;
        pulse_start(8);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pairs", 32'(pairs_done), 32'd0);
        check("arst_dp_empty", 32'(dp_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Lockstep: single-sided I write
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        check("lock_set", 32'(lockstep_err), 32'(exp_err));
        repeat (3) step();
        check("lock_sticky", 32'(lockstep_err), 32'(exp_err));
        pulse_start(0);
        check("lock_clear", 32'(lockstep_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/read_iq_ctrl.md
# read_iq_ctrl

Run controller for the `read_iq` unpacking stage of the FM receiver front end. It sits between the raw sample FIFO and `read_iq`. Per run it admits exactly N 32-bit IQ words into the stage, then counts the resulting I/Q sample pairs written to the I and Q FIFOs. It keeps both output FIFOs in lockstep and reports `done` once all N pairs have landed, giving the demodulator chain a start/done handshake.

## Interface
- CNT_WIDTH, 16, width of the run length and of the pair counters
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches `run_len` and begins a run
- abort  in  1  one-cycle pulse; terminates the current run
- run_len  in  CNT_WIDTH  number of IQ words/pairs in the run
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; held until the next accepted `start`
- pairs_done  out  CNT_WIDTH  pairs written in the current or last run
- src_empty  in  1  empty flag of the raw sample FIFO
- src_rd_en  out  1  read enable to the raw sample FIFO
- dp_empty  out  1  gated empty flag presented to `read_iq` inA_empty
- dp_rd_en  in  1  `read_iq` inA_rd_en
- i_full, q_full  in  1 each  full flags of the I and Q output FIFOs
- dp_full  out  1  gated full flag to both `read_iq` full inputs
- dp_i_wr_en, dp_q_wr_en  in  1 each  `read_iq` I/Q write enables (observed only)
- lockstep_err  out  1  sticky lockstep violation flag (see Configuration)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`:
  - latch `run_len`
  - clear `words_issued`, `pairs_done` and `lockstep_err`
  - go to RUN
- If `run_len` is 0 at `start`, go directly to DONE.
- `start` while `busy` is ignored.
- Read gating:
  - `allow = (state==RUN) && words_issued < len`
  - `dp_empty = src_empty | !allow`
  - `src_rd_en = dp_rd_en & allow & !src_empty`
  - `words_issued` increments on each `src_rd_en`.
- RUN → DRAIN on the cycle `words_issued` reaches `len`.
- DRAIN → DONE on the cycle `pairs_done` reaches `len`.
- `dp_full = i_full | q_full`. Both outputs stall together, so I and Q writes never split.
- `pairs_done` increments on `dp_i_wr_en & dp_q_wr_en`.
- `abort` in RUN or DRAIN:
  - go to IDLE next edge
  - `done` stays 0
  - `pairs_done` holds
  - `src_rd_en` is forced 0 in the same cycle
- `abort` has priority over `start`.
- Counters are unsigned CNT_WIDTH. They never exceed `len`, so no wrap-around is possible.

## Timing
- Reset values: state IDLE; `busy`, `done`, `src_rd_en`, `lockstep_err` = 0; `dp_empty` = 1; `dp_full` = `i_full|q_full` (combinational); `pairs_done` = 0.
- `start` at edge k: `busy` = 1 after edge k. The first `src_rd_en` is possible in the cycle after edge k.
- `src_rd_en`, `dp_empty` and `dp_full` are combinational from registered state and inputs; zero latency.
- `done` rises the cycle after the last pair write.
- `busy` falls in the same cycle that `done` rises.
- Asynchronous reset mid-run returns to IDLE immediately. External FIFOs are not flushed.

## Configuration
- `READ_IQ_CTRL_LOCKSTEP_CHK_EN` defined:
  - `lockstep_err` is set when `dp_i_wr_en != dp_q_wr_en` in any cycle, or when `dp_rd_en & !allow`.
  - The flag is sticky until the next accepted `start`.
  - A single-sided write does not increment `pairs_done`.
- Not defined:
  - `lockstep_err` is tied 0.
  - `pairs_done` increments on `dp_i_wr_en` alone.

## Structure
- Package `read_iq_ctrl_pkg` holds:
  - state enum `iq_ctrl_state_t`
  - default `IQ_CTRL_CNT_WIDTH = 16`
- One sub-module, `iq_run_counter`: a CNT_WIDTH up-counter with clear, increment and terminal-compare (`== len`) output. It is instantiated twice: words issued and pairs done.

## Test plan
- Basic run: reset; `run_len`=8; source holds 20 words; both output FIFOs empty → exactly 8 `src_rd_en`, `pairs_done`=8, `done`=1, 12 words remain in the source.
- Zero length: `start` with `run_len`=0 → `done`=1 one cycle later; no `src_rd_en`; `busy` never 1.
- Backpressure: `run_len`=16; hold `q_full`=1 for cycles 5–30 → `dp_full`=1 throughout, no write in that window, run completes with 16 I and 16 Q entries.
- Abort: `run_len`=100; `abort` after 10 pairs → IDLE next cycle, `done`=0, `src_rd_en`=0, `pairs_done`=10; a new `start` with 4 → `done` with `pairs_done`=4.
- Starved source: `run_len`=5; `src_empty`=1 for 50 cycles → state stays RUN, `dp_empty`=1; after 5 words are supplied → `done`.
- Lockstep check (macro defined): inject `dp_i_wr_en`=1 with `dp_q_wr_en`=0 for one cycle → `lockstep_err`=1 and sticky; the next `start` clears it.
